// File: rtl/clk_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_ctrl_pkg
// Description : Shared encodings for the clock-step controller. It holds the
//               mode-select codes, the controller state enum, and the
//               mode-to-state decode.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_ctrl_pkg;

    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

    typedef enum logic [1:0] {
        S_HALT = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10
    } clk_state_t;

    // Mode 2'b11 is reserved. It parks the controller in HALT so that a
    // glitching selector never produces ticks.
    function automatic clk_state_t mode_to_state(input logic [1:0] mode);
        clk_state_t st;
        st = S_HALT;
        case (mode)
            MODE_RUN:  st = S_RUN;
            MODE_STEP: st = S_STEP;
            default:   st = S_HALT;
        endcase
        return st;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rise_detect.sv
`default_nettype none
// ============================================================================
// Module      : rise_detect
// Description : 1-bit rising-edge detector with a registered output pulse.
//               Ports: clk_100Mhz (clock), rst_n (async active-low reset),
//               sig_in (level input), rise (one-cycle pulse, registered).
// Revision    : 1.0 - initial release
// ============================================================================
module rise_detect (
    input  logic clk_100Mhz,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise
);

    logic r_sig_q;
    logic r_rise;

    // The pulse is registered, so it appears one cycle after the input is
    // first sampled high. A consumer that also registers its response sees
    // the effect two cycles after the press.
    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_sig_q <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sig_q <= sig_in;
            r_rise  <= sig_in & ~r_sig_q;
        end
    end

    assign rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/clk_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_step_ctrl
// Description : Runtime-programmable clock-enable generator for the CPU
//               driver layer. It supports three modes: free-running divide,
//               halt, and single step from a debounced button.
//               Ports:
//                 clk_100Mhz - board clock
//                 rst_n      - async active-low reset
//                 div_value  - new divisor, taken when div_load is high
//                 div_load   - one-cycle divisor load strobe
//                 mode       - 00 HALT, 01 RUN, 10 STEP, 11 HALT
//                 step_req   - debounced step button level
//                 tick       - registered one-cycle enable
//                 clk_slow   - registered, toggles on every tick
//                 running    - registered, high while in RUN
// Revision    : 1.0 - initial release
// ============================================================================
module clk_step_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int          CNT_W       = 27,
    parameter int unsigned DEFAULT_DIV = 100_000_000
) (
    input  logic             clk_100Mhz,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] div_value,
    input  logic             div_load,
    input  logic [1:0]       mode,
    input  logic             step_req,
    output logic             tick,
    output logic             clk_slow,
    output logic             running
);

    localparam logic [CNT_W-1:0] c_default_div = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);

    clk_state_t       r_state;
    clk_state_t       w_next_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] w_div_eff;
    logic             w_tc;
    logic             w_step_rise;
    logic             w_tick_set;
    logic             r_tick;
    logic             r_slow;
    logic             r_running;

    rise_detect u_step_rise (
        .clk_100Mhz (clk_100Mhz),
        .rst_n      (rst_n),
        .sig_in     (step_req),
        .rise       (w_step_rise)
    );

    // State register
    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_HALT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode, terminal count, tick request and counter update.
    always_comb begin
        w_next_state = S_HALT;
        w_div_eff    = r_div;
        w_tc         = 1'b0;
        w_tick_set   = 1'b0;
        w_count_next = r_count + c_one;

        w_next_state = mode_to_state(mode);

        // A divisor of 0 behaves like 1, which gives a tick every cycle.
        if (r_div == '0) begin
            w_div_eff = c_one;
        end

        w_tc = (r_count == (w_div_eff - c_one));

        // The decision uses the current state, so a terminal count on the
        // cycle that leaves RUN still fires. A step edge fires only if the
        // controller is already in STEP. Edges seen in other states are
        // dropped, because the rise pulse lasts only one cycle.
        case (r_state)
            S_RUN:   w_tick_set = w_tc;
            S_STEP:  w_tick_set = w_step_rise;
            default: w_tick_set = 1'b0;
        endcase

        // The period restarts on any state change, on any divisor load,
        // and at the wrap. Outside RUN the counter is held at zero.
        if ((r_state != S_RUN) || (w_next_state != r_state) || div_load || w_tc) begin
            w_count_next = '0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_div     <= c_default_div;
            r_tick    <= 1'b0;
            r_slow    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_count   <= w_count_next;
            if (div_load) begin
                r_div <= div_value;
            end
            r_tick    <= w_tick_set;
            r_slow    <= r_slow ^ w_tick_set;
            r_running <= (w_next_state == S_RUN);
        end
    end

    assign tick     = r_tick;
    assign clk_slow = r_slow;
    assign running  = r_running;

endmodule
`default_nettype wire
